// File: rtl/fabric_mesh_cfg.sv
// rtl/fabric_mesh_cfg.sv - configurable tile mesh with double-buffered configuration load
//
// clb: one logic tile.
//   confi[7:0]   3-input LUT truth table, index {nbr, local_inputs[1], local_inputs[0]}
//   confi[9:8]   neighbour select for the LUT's third input: 0 north, 1 east, 2 south, 3 west
//   confi[10]    local_output taken from the tile flop (1) or straight from the LUT (0)
//   confi[11]    drive to_east / to_south with the tile flop
//   confi[12]    drive to_west / to_north with the tile flop
//   Ports: clk, rst_ni (sync active-low), confi, local_inputs, from_*, to_*, local_output.
//
// fabric_mesh_cfg: ROWS x COLS mesh of clb tiles with a word-serial configuration loader.
//   clk, rst                 clock, synchronous active-high reset
//   cfg_start                begin or restart a configuration load
//   cfg_valid/cfg_word       one configuration word per tile, row-major order
//   cfg_ready                high while a load is in progress
//   cfg_done                 high while the committed configuration is running
//   user_inputs              broadcast to every tile's local_inputs
//   out_sel/user_output      registered output of the selected tile
//   rd_idx/rd_cfg            combinational readback of a tile's active configuration

module clb (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic [12:0] confi,
    input  logic [1:0]  local_inputs,
    input  logic        from_north,
    input  logic        from_east,
    input  logic        from_south,
    input  logic        from_west,
    output logic        to_north,
    output logic        to_east,
    output logic        to_south,
    output logic        to_west,
    output logic        local_output
);
    logic       nbr;
    logic [2:0] lut_idx;
    logic [7:0] lut;
    logic       lut_out;
    logic       ff_q;

    always_comb begin
        nbr = 1'b0;
        case (confi[9:8])
            2'd0:    nbr = from_north;
            2'd1:    nbr = from_east;
            2'd2:    nbr = from_south;
            default: nbr = from_west;
        endcase
    end

    assign lut     = confi[7:0];
    assign lut_idx = {nbr, local_inputs};
    assign lut_out = lut[lut_idx];

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            ff_q <= 1'b0;
        end else begin
            ff_q <= lut_out;
        end
    end

    // Neighbour outputs come only from the flop so the mesh never forms a
    // combinational ring between adjacent tiles.
    assign to_east      = ff_q & confi[11];
    assign to_south     = ff_q & confi[11];
    assign to_west      = ff_q & confi[12];
    assign to_north     = ff_q & confi[12];
    assign local_output = confi[10] ? ff_q : lut_out;
endmodule

module fabric_mesh_cfg #(
    parameter  int ROWS  = 2,
    parameter  int COLS  = 2,
    parameter  int CFG_W = 13,
    localparam int N     = ROWS * COLS,
    localparam int SW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic [CFG_W-1:0] cfg_word,
    output logic             cfg_ready,
    output logic             cfg_done,
    input  logic [1:0]       user_inputs,
    input  logic [SW-1:0]    out_sel,
    output logic             user_output,
    input  logic [SW-1:0]    rd_idx,
    output logic [CFG_W-1:0] rd_cfg
);
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, RUN} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    count_q, count_d;
    logic             accept;
    logic [CFG_W-1:0] shadow_q [N];
    logic [CFG_W-1:0] active_q [N];
    logic             cfg_ready_q, cfg_done_q, user_output_q;
    logic             sel_out;
    logic             tile_rst_n;

    logic to_n [N];
    logic to_e [N];
    logic to_s [N];
    logic to_w [N];
    logic local_output [N];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            LOAD: begin
                // A restart wins over a word presented in the same cycle.
                if (cfg_start) begin
                    count_d = '0;
                end else if (cfg_valid) begin
                    accept  = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == SW'(N - 1)) begin
                        state_d = COMMIT;
                        count_d = '0;
                    end
                end
            end
            COMMIT: state_d = RUN;
            RUN: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_out = 1'b0;
        if (state_q == RUN) begin
            for (int k = 0; k < N; k++) begin
                if (out_sel == SW'(k)) sel_out = local_output[k];
            end
        end
    end

    always_comb begin
        rd_cfg = '0;
        for (int k = 0; k < N; k++) begin
            if (rd_idx == SW'(k)) rd_cfg = active_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            cfg_ready_q   <= 1'b0;
            cfg_done_q    <= 1'b0;
            user_output_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            cfg_ready_q   <= (state_d == LOAD);
            cfg_done_q    <= (state_d == RUN);
            user_output_q <= sel_out;
            if (accept) shadow_q[count_q] <= cfg_word;
            if (state_q == COMMIT) begin
                for (int k = 0; k < N; k++) active_q[k] <= shadow_q[k];
            end
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign cfg_done    = cfg_done_q;
    assign user_output = user_output_q;

    // Tiles keep running on the old configuration during LOAD; they are held
    // in reset only while nothing is configured or the new one is being copied.
    assign tile_rst_n = !(rst || state_q == IDLE || state_q == COMMIT);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int K = r * COLS + c;
            logic fn, fe, fs, fw;

            if (r > 0) begin : g_n
                assign fn = to_s[K - COLS];
            end else begin : g_nb
                assign fn = 1'b0;
            end
            if (r < ROWS - 1) begin : g_s
                assign fs = to_n[K + COLS];
            end else begin : g_sb
                assign fs = 1'b0;
            end
            if (c > 0) begin : g_w
                assign fw = to_e[K - 1];
            end else begin : g_wb
                assign fw = 1'b0;
            end
            if (c < COLS - 1) begin : g_e
                assign fe = to_w[K + 1];
            end else begin : g_eb
                assign fe = 1'b0;
            end

            clb u_clb (
                .clk          (clk),
                .rst_ni       (tile_rst_n),
                .confi        (active_q[K]),
                .local_inputs (user_inputs),
                .from_north   (fn),
                .from_east    (fe),
                .from_south   (fs),
                .from_west    (fw),
                .to_north     (to_n[K]),
                .to_east      (to_e[K]),
                .to_south     (to_s[K]),
                .to_west      (to_w[K]),
                .local_output (local_output[K])
            );
        end
    end
endmodule

// File: tb/tb_fabric_mesh_cfg.sv
// tb/tb_fabric_mesh_cfg.sv - self-checking bench for fabric_mesh_cfg (2x3 mesh)
module tb_fabric_mesh_cfg;
    localparam int N = 6;

    logic        clk = 1'b0;
    logic        rst, cfg_start, cfg_valid;
    logic [12:0] cfg_word;
    logic        cfg_ready, cfg_done;
    logic [1:0]  user_inputs;
    logic [2:0]  out_sel, rd_idx;
    logic        user_output;
    logic [12:0] rd_cfg;

    int errors = 0;
    int checks = 0;
    int accepts = 0;
    logic [12:0] pend[$];
    logic [12:0] model_active [N];
    logic [12:0] tab [N];
    logic [12:0] e;

    fabric_mesh_cfg #(.ROWS(2), .COLS(3), .CFG_W(13)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .cfg_valid   (cfg_valid),
        .cfg_word    (cfg_word),
        .cfg_ready   (cfg_ready),
        .cfg_done    (cfg_done),
        .user_inputs (user_inputs),
        .out_sel     (out_sel),
        .user_output (user_output),
        .rd_idx      (rd_idx),
        .rd_cfg      (rd_cfg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic with_word);
        cfg_start = 1'b1;
        cfg_valid = with_word;
        cfg_word  = 13'h0FF;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    // Presents words with cfg_valid dropped every other cycle; accepted words
    // go to the pending scoreboard queue.
    task automatic drive_words(input logic [12:0] first, input int cnt, input bit use_tab);
        int got = 0;
        int cyc = 0;
        bit hit;
        while (got < cnt && cyc < 200) begin
            cfg_valid = (cyc % 2 == 0);
            cfg_word  = use_tab ? tab[got] : first + 13'(got);
            hit = cfg_valid && cfg_ready;
            tick();
            cyc++;
            if (hit) begin
                got++;
                accepts++;
                pend.push_back(cfg_word);
            end
        end
        cfg_valid = 1'b0;
        checks++;
        if (got != cnt) begin
            errors++;
            $display("FAIL drive_words accepted=%0d required=%0d", got, cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_start = 0; cfg_valid = 0; cfg_word = 0;
        user_inputs = 0; out_sel = 0; rd_idx = 0;
        tick(); tick();
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", cfg_ready); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", cfg_done); end
        checks++; if (user_output !== 1'b0) begin errors++; $display("FAIL reset_uo got=%b want=0", user_output); end
        for (int k = 0; k < N; k++) begin
            rd_idx = 3'(k); #1;
            checks++;
            if (rd_cfg !== 13'h0) begin errors++; $display("FAIL reset_rd k=%0d got=%h want=0", k, rd_cfg); end
            model_active[k] = 13'h0;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_load();
        pend.delete();
        accepts = 0;
        pulse_start(1'b0);
        drive_words(13'h001, 6, 1'b0);
        checks++; if (accepts !== 6) begin errors++; $display("FAIL full_accepts got=%0d want=6", accepts); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL full_ready_after got=%b want=0", cfg_ready); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL full_done_commit got=%b want=0", cfg_done); end
        tick();
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL full_done got=%b want=1", cfg_done); end
        for (int k = 0; k < N; k++) begin
            e = (pend.size() > 0) ? pend.pop_front() : 13'h1FFF;
            rd_idx = 3'(k); #1;
            checks++;
            if (rd_cfg !== e) begin errors++; $display("FAIL full_rd k=%0d got=%h want=%h", k, rd_cfg, e); end
            model_active[k] = e;
        end
    endtask

    task automatic test_out_of_range();
        rd_idx = 3'd6; #1;
        checks++; if (rd_cfg !== 13'h0) begin errors++; $display("FAIL oor_rd6 got=%h want=0", rd_cfg); end
        rd_idx = 3'd7; #1;
        checks++; if (rd_cfg !== 13'h0) begin errors++; $display("FAIL oor_rd7 got=%h want=0", rd_cfg); end
        out_sel = 3'd7; user_inputs = 2'b11;
        tick();
        checks++; if (user_output !== 1'b0) begin errors++; $display("FAIL oor_sel7 got=%b want=0", user_output); end
    endtask

    task automatic test_live_reload();
        pend.delete();
        pulse_start(1'b0);
        drive_words(13'h040, 4, 1'b0);
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL live_ready got=%b want=1", cfg_ready); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL live_done_load got=%b want=0", cfg_done); end
        for (int k = 0; k < N; k++) begin
            rd_idx = 3'(k); #1;
            checks++;
            if (rd_cfg !== model_active[k]) begin errors++; $display("FAIL live_hold k=%0d got=%h want=%h", k, rd_cfg, model_active[k]); end
        end
        drive_words(13'h044, 2, 1'b0);
        rd_idx = 3'd0; #1;
        checks++; if (rd_cfg !== model_active[0]) begin errors++; $display("FAIL live_commit_old got=%h want=%h", rd_cfg, model_active[0]); end
        tick();
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL live_done got=%b want=1", cfg_done); end
        for (int k = 0; k < N; k++) begin
            e = (pend.size() > 0) ? pend.pop_front() : 13'h1FFF;
            rd_idx = 3'(k); #1;
            checks++;
            if (rd_cfg !== e) begin errors++; $display("FAIL live_rd k=%0d got=%h want=%h", k, rd_cfg, e); end
            model_active[k] = e;
        end
    endtask

    task automatic test_restart();
        pend.delete();
        pulse_start(1'b0);
        drive_words(13'h001, 3, 1'b0);
        pulse_start(1'b1);
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL restart_ready got=%b want=1", cfg_ready); end
        pend.delete();
        drive_words(13'h100, 6, 1'b0);
        tick();
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL restart_done got=%b want=1", cfg_done); end
        for (int k = 0; k < N; k++) begin
            e = (pend.size() > 0) ? pend.pop_front() : 13'h1FFF;
            rd_idx = 3'(k); #1;
            checks++;
            if (rd_cfg !== e) begin errors++; $display("FAIL restart_rd k=%0d got=%h want=%h", k, rd_cfg, e); end
            model_active[k] = e;
        end
    endtask

    task automatic test_reset_midload();
        pend.delete();
        pulse_start(1'b0);
        drive_words(13'h011, 2, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b want=0", cfg_done); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got=%b want=0", cfg_ready); end
        for (int k = 0; k < N; k++) begin
            rd_idx = 3'(k); #1;
            checks++;
            if (rd_cfg !== 13'h0) begin errors++; $display("FAIL rstmid_rd k=%0d got=%h want=0", k, rd_cfg); end
        end
        pend.delete();
        pulse_start(1'b0);
        drive_words(13'h0A0, 6, 1'b0);
        tick();
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL rstmid_done2 got=%b want=1", cfg_done); end
        for (int k = 0; k < N; k++) begin
            e = (pend.size() > 0) ? pend.pop_front() : 13'h1FFF;
            rd_idx = 3'(k); #1;
            checks++;
            if (rd_cfg !== e) begin errors++; $display("FAIL rstmid_rd2 k=%0d got=%h want=%h", k, rd_cfg, e); end
            model_active[k] = e;
        end
    endtask

    task automatic test_user_output();
        // tile0: out=in0; tile1: flop of in0 driving east; tile2: out=west
        // neighbour; tile3: out=in1; tiles 4,5: constant 0.
        tab[0] = 13'h0AA; tab[1] = 13'hCAA; tab[2] = 13'h3F0;
        tab[3] = 13'h0CC; tab[4] = 13'h000; tab[5] = 13'h000;
        pend.delete();
        pulse_start(1'b0);
        drive_words(13'h000, 6, 1'b1);
        tick();
        out_sel = 3'd0; user_inputs = 2'b01; tick();
        checks++; if (user_output !== 1'b1) begin errors++; $display("FAIL uo_t0_in0 got=%b want=1", user_output); end
        user_inputs = 2'b10; tick();
        checks++; if (user_output !== 1'b0) begin errors++; $display("FAIL uo_t0_in1 got=%b want=0", user_output); end
        out_sel = 3'd3; tick();
        checks++; if (user_output !== 1'b1) begin errors++; $display("FAIL uo_t3_in1 got=%b want=1", user_output); end
        user_inputs = 2'b01; tick();
        checks++; if (user_output !== 1'b0) begin errors++; $display("FAIL uo_t3_in0 got=%b want=0", user_output); end
        out_sel = 3'd2; tick(); tick();
        checks++; if (user_output !== 1'b1) begin errors++; $display("FAIL uo_mesh_hi got=%b want=1", user_output); end
        user_inputs = 2'b00; tick();
        checks++; if (user_output !== 1'b1) begin errors++; $display("FAIL uo_mesh_lag got=%b want=1", user_output); end
        tick();
        checks++; if (user_output !== 1'b0) begin errors++; $display("FAIL uo_mesh_lo got=%b want=0", user_output); end
        out_sel = 3'd4; user_inputs = 2'b11; tick();
        checks++; if (user_output !== 1'b0) begin errors++; $display("FAIL uo_t4 got=%b want=0", user_output); end
        out_sel = 3'd0; tick();
        checks++; if (user_output !== 1'b1) begin errors++; $display("FAIL uo_t0_hi got=%b want=1", user_output); end
        out_sel = 3'd7; tick();
        checks++; if (user_output !== 1'b0) begin errors++; $display("FAIL uo_sel7 got=%b want=0", user_output); end
        out_sel = 3'd6; tick();
        checks++; if (user_output !== 1'b0) begin errors++; $display("FAIL uo_sel6 got=%b want=0", user_output); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_load();
        test_out_of_range();
        test_live_reload();
        test_restart();
        test_reset_midload();
        test_user_output();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
